fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I pipeline, directly upstream of the instruction decode stage whose main decoder consumes `opcode`/`func3`. It owns the fetch PC, issues word requests to instruction memory over a valid/ready handshake, tolerates variable memory latency, and buffers returned instructions in a small FIFO. It presents `{instr, pc, pc+4}` to decode over a valid/ready handshake and discards wrong-path fetches on a branch/jump redirect.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, the FIFO entry type and an address helper
// for the instruction fetch stage.
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force an address onto a word boundary; redirect targets may carry junk low bits.
    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch entries between the memory
// response path and decode. Flush takes priority over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;

    // Storage writes plus pointer/occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + AW'(1);
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues credit-limited word requests to
// instruction memory, drops wrong-path responses after a redirect and
// hands buffered instructions to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetchPc_q, fetchPc_d;
    logic [XLEN-1:0] rspPc_q, rspPc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   dropCnt_q, dropCnt_d;
    logic [CW-1:0]   fifoCount;
    fetch_entry_t    pushEntry;
    fetch_entry_t    headEntry;
    logic            hasCredit;
    logic            reqFire;
    logic            rspKeep;
    logic            popFire;

    // Every request in flight or result sitting in the FIFO holds one slot, so a response can never overflow the FIFO.
    assign hasCredit      = ({1'b0, outstanding_q} + {1'b0, fifoCount}) < DEPTH_W;
    assign imem_req_valid = rst_n && !redirect_valid && hasCredit;
    assign imem_req_addr  = fetchPc_q;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign rspKeep        = imem_rsp_valid && !redirect_valid && (dropCnt_q == '0);
    assign if_valid       = (fifoCount != '0) && !redirect_valid;
    assign popFire        = if_valid && if_ready;
    assign pushEntry      = '{instr: imem_rsp_data, pc: rspPc_q};

    // Next-state for PCs and counters; a redirect overrides everything and turns all in-flight requests into drops.
    always_comb begin
        fetchPc_d     = fetchPc_q;
        rspPc_d       = rspPc_q;
        dropCnt_d     = dropCnt_q;
        outstanding_d = outstanding_q + CW'(reqFire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetchPc_d = wordAlign(redirect_pc);
            rspPc_d   = wordAlign(redirect_pc);
            dropCnt_d = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (reqFire) begin
                fetchPc_d = fetchPc_q + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (dropCnt_q != '0) begin
                    dropCnt_d = dropCnt_q - CW'(1);
                end else begin
                    rspPc_d = rspPc_q + 32'd4;
                end
            end
        end
    end

    // PC and credit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchPc_q     <= RESET_PC;
            rspPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            fetchPc_q     <= fetchPc_d;
            rspPc_q       <= rspPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rspKeep),
        .data_i  (pushEntry),
        .pop_i   (popFire),
        .flush_i (redirect_valid),
        .head_o  (headEntry),
        .count_o (fifoCount)
    );

    assign if_instr    = headEntry.instr;
    assign if_pc       = headEntry.pc;
    assign if_pc_plus4 = headEntry.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit. Instance A runs
// against a variable-latency memory with random stalls and redirects;
// instance B starts near the top of the address space with a 1-cycle memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] RESET_A = 32'h0000_0000;
    localparam logic [31:0] RESET_B = 32'hFFFF_FFF8;

    logic        clk;
    logic        rst_n;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    logic        reqValidB;
    logic [31:0] reqAddrB;
    logic        rspValidB;
    logic [31:0] rspDataB;
    logic        ifValidB;
    logic [31:0] ifInstrB;
    logic [31:0] ifPcB;
    logic [31:0] ifPcPlus4B;

    // A memory request in flight; live goes low once a redirect makes it wrong-path.
    typedef struct {
        logic [31:0] addr;
        bit          live;
        int          due;
    } memReq_t;

    // An instruction decode is expected to receive, in program order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          returned;
        int          visCycle;
    } expItem_t;

    memReq_t     memQ[$];
    expItem_t    expQ[$];

    int          vectors     = 0;
    int          miscompares = 0;
    int          cycNum      = 0;

    int          pReady      = 100;
    int          pIfReady    = 100;
    int          pRedir      = 0;
    int          latMin      = 1;
    int          latMax      = 1;
    bit          forceRedir  = 0;
    logic [31:0] forceTarget = '0;

    logic [31:0] nextAddr    = RESET_A;
    int          lastDue     = 0;
    logic        expValidA;

    int          sinceB      = 0;
    int          issuedB     = 0;
    int          poppedB     = 0;
    logic        lastFireB   = 0;
    logic [31:0] lastAddrB   = '0;

    fetch_unit #(
        .RESET_PC (RESET_A),
        .DEPTH    (DEPTH)
    ) dutA (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    fetch_unit #(
        .RESET_PC (RESET_B),
        .DEPTH    (DEPTH)
    ) dutB (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (reqValidB),
        .imem_req_ready (1'b1),
        .imem_req_addr  (reqAddrB),
        .imem_rsp_valid (rspValidB),
        .imem_rsp_data  (rspDataB),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .if_valid       (ifValidB),
        .if_ready       (1'b1),
        .if_instr       (ifInstrB),
        .if_pc          (ifPcB),
        .if_pc_plus4    (ifPcPlus4B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycNum);
        end
    endtask

    // Drive one cycle of random stimulus shortly after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        imem_req_ready = ($urandom_range(99) < pReady);
        if_ready       = ($urandom_range(99) < pIfReady);
        if (forceRedir) begin
            redirect_valid = 1'b1;
            redirect_pc    = forceTarget;
            forceRedir     = 0;
        end else begin
            redirect_valid = ($urandom_range(999) < pRedir);
            redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
        end
        if (rst_n && memQ.size() > 0 && memQ[0].due <= cycNum) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memData(memQ[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Hold reset for a few cycles while late memory responses keep arriving.
    task automatic applyReset(input int cycles);
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = $urandom;
        end
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
    endtask

    // Reference model for A: credit limit, request addresses, and which fetched words decode should see.
    task automatic modelStep();
        int      buffered;
        int      k;
        int      due;
        logic    expReq;
        bit      marked;
        memReq_t m;
        if (!rst_n) begin
            memQ.delete();
            expQ.delete();
            nextAddr = RESET_A;
            lastDue  = 0;
            checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            checkOutput("rst_req_addr", imem_req_addr, RESET_A);
            return;
        end
        buffered = 0;
        foreach (expQ[i]) begin
            if (expQ[i].returned && expQ[i].visCycle <= cycNum) buffered++;
        end
        expReq = !redirect_valid && ((memQ.size() + buffered) < DEPTH);
        checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, expReq});
        if (imem_req_valid) checkOutput("req_addr", imem_req_addr, nextAddr);
        if (imem_rsp_valid && memQ.size() > 0) begin
            m = memQ.pop_front();
            if (m.live && !redirect_valid) begin
                marked = 0;
                for (int i = 0; i < expQ.size(); i++) begin
                    if (!marked && !expQ[i].returned) begin
                        expQ[i].returned = 1;
                        expQ[i].visCycle = cycNum + 1;
                        marked           = 1;
                    end
                end
            end
        end
        if (redirect_valid) begin
            foreach (memQ[i]) memQ[i].live = 0;
            expQ.delete();
            nextAddr = redirect_pc & ~32'h3;
        end else if (imem_req_valid && imem_req_ready) begin
            k = $urandom_range(latMax, latMin);
            due = cycNum + k;
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back('{addr: nextAddr, live: 1'b1, due: due});
            expQ.push_back('{pc: nextAddr, instr: memData(nextAddr), returned: 1'b0, visCycle: 0});
            nextAddr = nextAddr + 32'd4;
        end
    endtask

    initial forever begin
        @(posedge clk);
        #4;
        modelStep();
    end

    // Monitor: whenever A offers an instruction, pop the scoreboard and compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
            checkOutput("rst_if_instr", if_instr, 32'd0);
            checkOutput("rst_if_pc", if_pc, 32'd0);
            checkOutput("rst_if_pc_plus4", if_pc_plus4, 32'd4);
        end else begin
            expValidA = !redirect_valid && expQ.size() > 0 && expQ[0].returned && expQ[0].visCycle <= cycNum;
            checkOutput("if_valid", {31'b0, if_valid}, {31'b0, expValidA});
            if (if_valid && expValidA) begin
                checkOutput("if_pc", if_pc, expQ[0].pc);
                checkOutput("if_instr", if_instr, expQ[0].instr);
                checkOutput("if_pc_plus4", if_pc_plus4, expQ[0].pc + 32'd4);
                if (if_ready) void'(expQ.pop_front());
            end
        end
    end

    // Instance B memory: answers every accepted request exactly one cycle later.
    initial begin
        rspValidB = 1'b0;
        rspDataB  = '0;
        forever begin
            @(posedge clk);
            #1;
            rspValidB = rst_n && lastFireB;
            rspDataB  = memData(lastAddrB);
        end
    end

    // Instance B checks: address wrap past 0xFFFF_FFFC and one-per-cycle throughput.
    initial forever begin
        @(posedge clk);
        #4;
        if (!rst_n) begin
            sinceB    = 0;
            issuedB   = 0;
            poppedB   = 0;
            lastFireB = 1'b0;
            checkOutput("B_rst_req_valid", {31'b0, reqValidB}, 32'd0);
            checkOutput("B_rst_req_addr", reqAddrB, RESET_B);
            checkOutput("B_rst_pc_plus4", ifPcPlus4B, 32'd4);
        end else begin
            checkOutput("B_req_valid", {31'b0, reqValidB}, 32'd1);
            if (reqValidB) checkOutput("B_req_addr", reqAddrB, RESET_B + 32'(issuedB) * 32'd4);
            checkOutput("B_if_valid", {31'b0, ifValidB}, {31'b0, (sinceB >= 2)});
            if (ifValidB) begin
                checkOutput("B_if_pc", ifPcB, RESET_B + 32'(poppedB) * 32'd4);
                checkOutput("B_if_instr", ifInstrB, memData(RESET_B + 32'(poppedB) * 32'd4));
                checkOutput("B_if_pc_plus4", ifPcPlus4B, RESET_B + 32'(poppedB + 1) * 32'd4);
                poppedB++;
            end
            lastFireB = reqValidB;
            lastAddrB = reqAddrB;
            if (reqValidB) issuedB++;
            sinceB++;
        end
    end

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        #2 rst_n = 1'b0;
        applyReset(2);

        // Streaming with a 1-cycle memory and decode always ready.
        repeat (30) applyStimulus();

        // Decode stalls long enough for the credits to run out, then drains.
        pIfReady = 0;
        repeat (10) applyStimulus();
        pIfReady = 100;
        repeat (20) applyStimulus();

        // 3-cycle memory, redirect to a misaligned target while responses stream in.
        latMin = 3;
        latMax = 3;
        repeat (12) applyStimulus();
        forceRedir  = 1;
        forceTarget = 32'h0000_0103;
        applyStimulus();
        repeat (12) applyStimulus();

        // Redirect while a request is stalled by memory.
        pReady = 0;
        repeat (3) applyStimulus();
        forceRedir  = 1;
        forceTarget = 32'h0000_0204;
        applyStimulus();
        pReady = 100;
        repeat (12) applyStimulus();

        // Reset in the middle of traffic with requests in flight and results buffered.
        applyReset(1);
        pIfReady = 0;
        repeat (5) applyStimulus();
        applyReset(2);
        pIfReady = 100;
        repeat (20) applyStimulus();

        // Fully random traffic, variable latency, occasional redirects.
        pReady   = 70;
        pIfReady = 70;
        pRedir   = 40;
        latMin   = 1;
        latMax   = 5;
        repeat (3000) applyStimulus();

        // Short latency with frequent redirects.
        pReady   = 85;
        pIfReady = 50;
        pRedir   = 120;
        latMin   = 1;
        latMax   = 2;
        repeat (2000) applyStimulus();

        @(posedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
